// File: rtl/fetch_controller.sv
// Instruction fetch unit: PC register, 2-entry {inst, pc} FIFO toward decode, and a
// program-memory port shared by redirect, debug reads and sequential fetch.
module fetch_controller #(
  parameter int                    DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic [DATA_WIDTH-1:0] mem_address,
  input  logic [DATA_WIDTH-1:0] mem_instruction,
  output logic                  inst_valid,
  input  logic                  inst_ready,
  output logic [DATA_WIDTH-1:0] inst_data,
  output logic [DATA_WIDTH-1:0] inst_pc,
  input  logic                  redirect_valid,
  input  logic [DATA_WIDTH-1:0] redirect_pc,
  input  logic                  halt,
  input  logic                  dbg_req,
  input  logic [DATA_WIDTH-1:0] dbg_addr,
  output logic                  dbg_ack,
  output logic [DATA_WIDTH-1:0] dbg_data,
  output logic                  halted
);

  typedef enum logic {ST_RUN, ST_HALTED} state_t;

  state_t                r_state;
  logic [DATA_WIDTH-1:0] r_pc;
  logic [1:0]            r_count;
  logic [DATA_WIDTH-1:0] r_fifo_inst [2];
  logic [DATA_WIDTH-1:0] r_fifo_pc   [2];
  logic                  r_dbg_ack;
  logic [DATA_WIDTH-1:0] r_dbg_data;

  logic w_pop;
  logic w_dbg;
  logic w_fetch;

  // Entry 0 is always the head; the FIFO shifts toward it on a pop.
  assign inst_valid = (r_count != 2'd0);
  assign inst_data  = r_fifo_inst[0];
  assign inst_pc    = r_fifo_pc[0];
  assign dbg_ack    = r_dbg_ack;
  assign dbg_data   = r_dbg_data;
  assign halted     = (r_state == ST_HALTED);

  // Port priority: redirect > debug > fetch. A redirect cycle uses the port for nothing.
  always_comb begin
    w_pop       = inst_valid && inst_ready;
    w_dbg       = dbg_req && !redirect_valid;
    w_fetch     = (r_state == ST_RUN) && !halt && !redirect_valid && !dbg_req &&
                  ((r_count != 2'd2) || w_pop);
    mem_address = w_dbg ? dbg_addr : r_pc;
  end

  // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_RUN;
      r_pc       <= RESET_PC;
      r_count    <= 2'd0;
      r_dbg_ack  <= 1'b0;
      r_dbg_data <= '0;
      // NOTE: FIFO storage is reset because its head drives inst_data/inst_pc directly.
      for (int i = 0; i < 2; i++) begin
        r_fifo_inst[i] <= '0;
        r_fifo_pc[i]   <= '0;
      end
    end else begin
      r_state   <= halt ? ST_HALTED : ST_RUN;
      r_dbg_ack <= w_dbg;
      if (w_dbg) r_dbg_data <= mem_instruction;

      if (redirect_valid) begin
        r_pc    <= redirect_pc;
        r_count <= 2'd0;
      end else begin
        if (w_fetch) r_pc <= r_pc + DATA_WIDTH'(4);
        case ({w_fetch, w_pop})
          2'b10: begin
            r_fifo_inst[r_count[0]] <= mem_instruction;
            r_fifo_pc[r_count[0]]   <= r_pc;
            r_count                 <= r_count + 2'd1;
          end
          2'b01: begin
            r_fifo_inst[0] <= r_fifo_inst[1];
            r_fifo_pc[0]   <= r_fifo_pc[1];
            r_count        <= r_count - 2'd1;
          end
          2'b11: begin
            if (r_count == 2'd2) begin
              r_fifo_inst[0] <= r_fifo_inst[1];
              r_fifo_pc[0]   <= r_fifo_pc[1];
              r_fifo_inst[1] <= mem_instruction;
              r_fifo_pc[1]   <= r_pc;
            end else begin
              r_fifo_inst[0] <= mem_instruction;
              r_fifo_pc[0]   <= r_pc;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fetch_controller.sv
// Directed bench for fetch_controller; ROM model returns 0x1000 + word index.
module tb_fetch_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] mem_address;
  logic [31:0] mem_instruction;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        halt;
  logic        dbg_req;
  logic [31:0] dbg_addr;
  logic        dbg_ack;
  logic [31:0] dbg_data;
  logic        halted;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  assign mem_instruction = 32'h1000 + {2'b00, mem_address[31:2]};

  fetch_controller dut (
    .clk             (clk),
    .reset           (reset),
    .mem_address     (mem_address),
    .mem_instruction (mem_instruction),
    .inst_valid      (inst_valid),
    .inst_ready      (inst_ready),
    .inst_data       (inst_data),
    .inst_pc         (inst_pc),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .halt            (halt),
    .dbg_req         (dbg_req),
    .dbg_addr        (dbg_addr),
    .dbg_ack         (dbg_ack),
    .dbg_data        (dbg_data),
    .halted          (halted)
  );

  // Leaves the bench at the negedge where reset has just been released.
  task automatic do_reset(input logic ready);
    @(negedge clk);
    reset = 1'b1; redirect_valid = 1'b0; halt = 1'b0; dbg_req = 1'b0; inst_ready = ready;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1; inst_ready = 1'b1; halt = 1'b1;
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0100;
    dbg_req = 1'b1; dbg_addr = 32'h0000_0020;
    repeat (2) @(negedge clk);
    redirect_valid = 1'b0; dbg_req = 1'b0; halt = 1'b0;
    #1;
    checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", inst_valid); end
    checks++; if (inst_data !== 32'h0) begin errors++; $display("FAIL reset_data got=%h exp=0", inst_data); end
    checks++; if (inst_pc !== 32'h0) begin errors++; $display("FAIL reset_pc got=%h exp=0", inst_pc); end
    checks++; if (dbg_ack !== 1'b0 || dbg_data !== 32'h0) begin errors++; $display("FAIL reset_dbg got=%b/%h exp=0/0", dbg_ack, dbg_data); end
    checks++; if (halted !== 1'b0) begin errors++; $display("FAIL reset_halted got=%b exp=0", halted); end
    checks++; if (mem_address !== 32'h0) begin errors++; $display("FAIL reset_addr got=%h exp=0", mem_address); end
  endtask

  task automatic test_stream;
    do_reset(1'b1);
    #1;
    checks++; if (mem_address !== 32'h0) begin errors++; $display("FAIL stream_first_addr got=%h exp=0", mem_address); end
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      checks++;
      if (inst_valid !== 1'b1 || inst_pc !== 32'(4 * k) || inst_data !== 32'(32'h1000 + k)) begin
        errors++;
        $display("FAIL stream_%0d got=%b/%h/%h exp=1/%h/%h", k, inst_valid, inst_pc, inst_data, 4 * k, 32'h1000 + k);
      end
    end
  endtask

  task automatic test_backpressure;
    do_reset(1'b0);
    repeat (5) @(negedge clk);
    #1;
    checks++; if (mem_address !== 32'h8) begin errors++; $display("FAIL bp_stall_addr got=%h exp=8", mem_address); end
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (inst_valid !== 1'b1 || inst_pc !== 32'(4 * k) || inst_data !== 32'(32'h1000 + k)) begin
        errors++;
        $display("FAIL bp_resume_%0d got=%b/%h/%h exp=1/%h/%h", k, inst_valid, inst_pc, inst_data, 4 * k, 32'h1000 + k);
      end
      inst_ready = 1'b1;
      @(negedge clk);
    end
  endtask

  task automatic test_redirect;
    do_reset(1'b0);
    repeat (3) @(negedge clk);
    redirect_valid = 1'b1; redirect_pc = 32'h40; inst_ready = 1'b1;
    @(negedge clk);
    redirect_valid = 1'b0;
    #1;
    checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL redir_flush got=%b exp=0", inst_valid); end
    checks++; if (mem_address !== 32'h40) begin errors++; $display("FAIL redir_addr got=%h exp=40", mem_address); end
    @(negedge clk);
    checks++; if (inst_valid !== 1'b1 || inst_pc !== 32'h40 || inst_data !== 32'h1010) begin errors++; $display("FAIL redir_first got=%b/%h/%h exp=1/40/1010", inst_valid, inst_pc, inst_data); end
    @(negedge clk);
    checks++; if (inst_valid !== 1'b1 || inst_pc !== 32'h44 || inst_data !== 32'h1011) begin errors++; $display("FAIL redir_second got=%b/%h/%h exp=1/44/1011", inst_valid, inst_pc, inst_data); end
  endtask

  task automatic test_pc_wrap;
    @(negedge clk);
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC; inst_ready = 1'b1;
    @(negedge clk);
    redirect_valid = 1'b0;
    @(negedge clk);
    checks++; if (inst_pc !== 32'hFFFF_FFFC || inst_data !== 32'h4000_0FFF) begin errors++; $display("FAIL wrap_top got=%h/%h exp=fffffffc/40000fff", inst_pc, inst_data); end
    @(negedge clk);
    checks++; if (inst_valid !== 1'b1 || inst_pc !== 32'h0 || inst_data !== 32'h1000) begin errors++; $display("FAIL wrap_zero got=%b/%h/%h exp=1/0/1000", inst_valid, inst_pc, inst_data); end
  endtask

  task automatic test_debug;
    do_reset(1'b1);
    repeat (2) @(negedge clk);
    dbg_req = 1'b1; dbg_addr = 32'h0C;
    #1;
    checks++; if (mem_address !== 32'h0C) begin errors++; $display("FAIL dbg_addr got=%h exp=c", mem_address); end
    @(negedge clk);
    dbg_req = 1'b0;
    checks++; if (dbg_ack !== 1'b1 || dbg_data !== 32'h1003) begin errors++; $display("FAIL dbg_ack got=%b/%h exp=1/1003", dbg_ack, dbg_data); end
    checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL dbg_pop got=%b exp=0", inst_valid); end
    @(negedge clk);
    checks++; if (dbg_ack !== 1'b0) begin errors++; $display("FAIL dbg_ack_pulse got=%b exp=0", dbg_ack); end
    checks++; if (inst_valid !== 1'b1 || inst_pc !== 32'h8 || inst_data !== 32'h1002) begin errors++; $display("FAIL dbg_resume8 got=%b/%h/%h exp=1/8/1002", inst_valid, inst_pc, inst_data); end
    @(negedge clk);
    checks++; if (inst_pc !== 32'hC || inst_data !== 32'h1003) begin errors++; $display("FAIL dbg_resume12 got=%h/%h exp=c/1003", inst_pc, inst_data); end
  endtask

  task automatic test_halt;
    do_reset(1'b0);
    repeat (3) @(negedge clk);
    halt = 1'b1; inst_ready = 1'b1;
    @(negedge clk);
    checks++; if (halted !== 1'b1) begin errors++; $display("FAIL halt_flag got=%b exp=1", halted); end
    checks++; if (inst_valid !== 1'b1 || inst_pc !== 32'h4) begin errors++; $display("FAIL halt_drain got=%b/%h exp=1/4", inst_valid, inst_pc); end
    repeat (3) @(negedge clk);
    #1;
    checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL halt_empty got=%b exp=0", inst_valid); end
    checks++; if (mem_address !== 32'h8) begin errors++; $display("FAIL halt_pc got=%h exp=8", mem_address); end
    halt = 1'b0;
    @(negedge clk);
    checks++; if (halted !== 1'b0) begin errors++; $display("FAIL unhalt_flag got=%b exp=0", halted); end
    @(negedge clk);
    checks++; if (inst_valid !== 1'b1 || inst_pc !== 32'h8 || inst_data !== 32'h1002) begin errors++; $display("FAIL unhalt_fetch got=%b/%h/%h exp=1/8/1002", inst_valid, inst_pc, inst_data); end
  endtask

  task automatic test_halt_redirect;
    do_reset(1'b0);
    repeat (3) @(negedge clk);
    halt = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h80;
    @(negedge clk);
    redirect_valid = 1'b0;
    #1;
    checks++; if (halted !== 1'b1 || inst_valid !== 1'b0) begin errors++; $display("FAIL haltredir_state got=%b/%b exp=1/0", halted, inst_valid); end
    checks++; if (mem_address !== 32'h80) begin errors++; $display("FAIL haltredir_pc got=%h exp=80", mem_address); end
    @(negedge clk);
    checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL haltredir_nofetch got=%b exp=0", inst_valid); end
    halt = 1'b0;
  endtask

  task automatic test_reset_mid_debug;
    do_reset(1'b1);
    repeat (3) @(negedge clk);
    dbg_req = 1'b1; dbg_addr = 32'h10; reset = 1'b1;
    @(negedge clk);
    dbg_req = 1'b0; reset = 1'b0;
    #1;
    checks++; if (dbg_ack !== 1'b0) begin errors++; $display("FAIL rstdbg_ack got=%b exp=0", dbg_ack); end
    checks++; if (mem_address !== 32'h0 || inst_valid !== 1'b0) begin errors++; $display("FAIL rstdbg_pc got=%h/%b exp=0/0", mem_address, inst_valid); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_pc_wrap();
    test_debug();
    test_halt();
    test_halt_redirect();
    test_reset_mid_debug();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fetch_controller.md
FETCH_CONTROLLER -- requirements
Module: fetch_controller

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, giving the width of addresses, instructions and PCs.
REQ-002 The block SHALL have parameter RESET_PC, default 32'h0000_0000, giving the PC loaded on reset.
REQ-003 The block SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 The block SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 The block SHALL have port mem_address  output  DATA_WIDTH  byte address driven to program memory (combinational-read ROM, word index = address[DW-1:2]).
REQ-006 The block SHALL have port mem_instruction  input  DATA_WIDTH  word returned by program memory in the same cycle.
REQ-007 The block SHALL have port inst_valid / inst_ready / inst_data / inst_pc  output / input / output DW / output DW  instruction stream to decode; a transfer occurs when valid and ready are both 1.
REQ-008 The block SHALL have port redirect_valid / redirect_pc  input 1 / input DW  branch/jump target load.
REQ-009 The block SHALL have port halt  input  1  request to stop fetching.
REQ-010 The block SHALL have port dbg_req / dbg_addr / dbg_ack / dbg_data  input 1 / input DW / output 1 / output DW  debug read port sharing program memory.
REQ-011 The block SHALL have port halted  output  1  high while the FSM is in HALTED.

Function
REQ-012 The PC register SHALL increment by 4 per fetch, modulo 2^DATA_WIDTH (wrap 0xFFFF_FFFC -> 0).
REQ-013 The 2-entry instruction FIFO SHALL store {inst, pc} per entry, with occupancy count 0..2; inst_valid = (count != 0); inst_data/inst_pc = head entry, all registered.
REQ-014 Memory port arbitration each cycle SHALL use fixed priority: redirect_valid > dbg_req > fetch.
REQ-015 A redirect cycle SHALL flush the FIFO (count <= 0, pop ignored), load PC <= redirect_pc, perform no fetch and no debug access; a pending dbg_req SHALL be served on a later cycle.
REQ-016 A debug cycle (dbg_req=1, no redirect) SHALL drive mem_address = dbg_addr, register dbg_data <= mem_instruction, and assert dbg_ack for exactly one cycle on the next cycle; PC and FIFO contents SHALL be unchanged, and a pop in that cycle SHALL still proceed.
REQ-017 dbg_req held high SHALL perform one debug access per cycle; fetch SHALL be starved while it is held.
REQ-018 A fetch SHALL occur when state=RUN, no redirect, no dbg_req and (count<2 or a pop occurs this cycle), driving mem_address = PC, pushing {mem_instruction, PC} and advancing PC.
REQ-019 When not fetching or debugging, mem_address SHALL equal PC.
REQ-020 Fetch-to-inst_valid latency SHALL be 1 cycle; a simultaneous push and pop at count=1 or 2 SHALL keep count unchanged and preserve order.
REQ-021 A pop with count=0 SHALL be impossible (valid=0); a push with count=2 and no pop SHALL NOT occur.
REQ-022 The FSM SHALL have states RUN and HALTED: RUN->HALTED when halt=1 (no fetch that cycle); HALTED->RUN when halt=0; redirect and debug SHALL be served in both states; the FIFO SHALL drain normally while HALTED.
REQ-023 halt and redirect in the same cycle SHALL both take effect (PC loaded, FIFO flushed, state HALTED).

Reset
REQ-024 reset=1 at a clock edge SHALL set PC=RESET_PC, count=0, state=RUN, inst_valid=0, inst_data=0, inst_pc=0, dbg_ack=0, dbg_data=0, halted=0, and SHALL override all other inputs, including mid-redirect or mid-debug.
REQ-025 The first fetch SHALL occur in the first cycle with reset=0 (address RESET_PC), with inst_valid=1 in the following cycle.

Verification
REQ-026 Reset release, inst_ready=1, ROM[i]=0x1000+i -> inst_pc 0,4,8,... with inst_data 0x1000,0x1001,... one per cycle, no gaps.
REQ-027 inst_ready=0 for 5 cycles -> count saturates at 2, PC stops at 8, mem_address=8; ready=1 -> stream resumes at pc 0 without loss or duplication.
REQ-028 Redirect to 0x40 while count=2 -> next cycle inst_valid=0; following cycles deliver pc 0x40, 0x44 with ROM[16], ROM[17].
REQ-029 dbg_req=1, dbg_addr=0x0C for one cycle during streaming -> mem_address=0x0C that cycle, dbg_ack=1 and dbg_data=ROM[3] next cycle, fetch stream skips no PC.
REQ-030 halt=1 with count=2 -> halted=1 next cycle, two entries drain, no further fetch; halt=0 -> fetch resumes at saved PC; reset asserted mid-debug -> dbg_ack=0 and PC=RESET_PC next cycle.
